// File: rtl/difftest_batch_pkg.sv
// Shared types and width helpers for the DiffTest step batcher.
//   batch_state_e : batcher FSM states (IDLE, COLLECT, DRAIN)
//   acc_width()   : accumulator width derived from the step width
//   step_max()    : largest value a single difftest_step can carry
package difftest_batch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } batch_state_e;

    // One extra bit so a full step can be emitted while more commits keep arriving.
    function automatic int acc_width(input int step_w);
        return step_w + 1;
    endfunction

    function automatic int step_max(input int step_w);
        return (1 << step_w) - 1;
    endfunction

endpackage

// File: rtl/batch_idle_timer.sv
// Idle timer for the step batcher: counts cycles in which a partial batch sits
// without being emitted, and flags expiry once TIMEOUT-1 such cycles are seen.
//   clock, reset : clock and synchronous active-high reset
//   clear        : restart the count (emission, return to idle)
//   count_en     : count this cycle
//   freeze       : hold the count as-is (overrides count_en, not clear)
//   expired      : count has reached TIMEOUT-1
module batch_idle_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    input  logic freeze,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Saturates at LAST so a held-off expiry stays asserted until cleared.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && !freeze && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches per-cycle commit counts into difftest_step pulses for the DiffTest
// endpoint. A batch leaves on reaching THRESHOLD, on idle timeout (optional),
// or while draining after a flush; hold suppresses emission only.
//   clock, reset   : clock and synchronous active-high reset
//   in_valid       : in_step is valid this cycle
//   in_step        : instructions committed this cycle (0 allowed)
//   in_ready       : accumulator has room for a full in_step
//   flush          : drain everything pending (remembered through hold)
//   hold           : no emission this cycle, accumulation continues
//   difftest_step  : registered step count, 0 = no step
//   pending        : current accumulator value
//   busy           : FSM is not idle
// Build option: define DIFFTEST_STEP_BATCH_TIMEOUT_EN to build the idle timer;
// without it partial batches leave only on threshold or flush.
//
// state   | meaning
// IDLE    | nothing pending
// COLLECT | accumulating a partial batch
// DRAIN   | flushing; emit every cycle until empty
module difftest_step_batcher
    import difftest_batch_pkg::*;
#(
    parameter int STEP_W    = 8,
    parameter int IN_W      = 4,
    parameter int THRESHOLD = 64,
    parameter int TIMEOUT   = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_step,
    output logic              in_ready,
    input  logic              flush,
    input  logic              hold,
    output logic [STEP_W-1:0] difftest_step,
    output logic [STEP_W:0]   pending,
    output logic              busy
);

    localparam int ACC_W = acc_width(STEP_W);
    localparam logic [ACC_W-1:0] STEP_MAX_A  = ACC_W'(step_max(STEP_W));
    localparam logic [ACC_W-1:0] THRESH_A    = ACC_W'(THRESHOLD);
    // Largest acc that can still absorb a maximum in_step without wrapping.
    localparam logic [ACC_W-1:0] READY_LIMIT = ACC_W'(((1 << ACC_W) - 1) - ((1 << IN_W) - 1));

    batch_state_e      state, state_next;
    logic [ACC_W-1:0]  acc, acc_next, accepted, emitted;
    logic              accept, emit, timer_expired;

    assign in_ready = (acc <= READY_LIMIT);
    assign accept   = in_valid && in_ready;
    assign accepted = accept ? ACC_W'(in_step) : '0;

    // acc != 0 keeps a stale timer or an empty drain from producing a zero step.
    assign emit     = !hold && (acc != '0) &&
                      ((acc >= THRESH_A) || timer_expired || (state == DRAIN));
    assign emitted  = emit ? ((acc > STEP_MAX_A) ? STEP_MAX_A : acc) : '0;
    assign acc_next = acc - emitted + accepted;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && (in_step != '0)) state_next = COLLECT;
            COLLECT: if (acc_next == '0) state_next = IDLE;
            DRAIN:   if (acc_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A flush with nothing left after this cycle has nothing to drain.
        if (flush) begin
            state_next = (acc_next == '0) ? IDLE : DRAIN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            acc           <= '0;
            difftest_step <= '0;
        end else begin
            state         <= state_next;
            acc           <= acc_next;
            difftest_step <= emitted[STEP_W-1:0];
        end
    end

`ifdef DIFFTEST_STEP_BATCH_TIMEOUT_EN
    batch_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (emit || (state_next == IDLE)),
        .count_en ((state == COLLECT) && !emit),
        .freeze   (hold),
        .expired  (timer_expired)
    );
`else
    // TIMEOUT has no effect without the timer.
    localparam int unused_timeout = TIMEOUT;
    assign timer_expired = 1'b0;
`endif

    assign pending = acc;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_difftest_step_batcher.sv
module tb_difftest_step_batcher;

    localparam int TIMEOUT = 256;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_step  = '0;
    logic       flush    = 1'b0;
    logic       hold     = 1'b0;
    logic       in_ready;
    logic [7:0] difftest_step;
    logic [8:0] pending;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    difftest_step_batcher dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_step       (in_step),
        .in_ready      (in_ready),
        .flush         (flush),
        .hold          (hold),
        .difftest_step (difftest_step),
        .pending       (pending),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset;
        reset = 1'b1; in_valid = 1'b0; in_step = '0; flush = 1'b0; hold = 1'b0;
        cyc(2);
        reset = 1'b0;
    endtask

    // Model: a pool of pending instructions; a step takes up to 255 out of it
    // whenever the pool is big enough, has idled long enough, or a flush is
    // outstanding, unless hold is up. Busy simply means the pool is non-empty.
    int m_acc = 0, m_step = 0, m_wait = 0;
    bit m_drain = 1'b0;
    int take, out, nxt;
    bit fire, tmo;

    always @(posedge clock) begin
        take = (in_valid && (m_acc <= 496)) ? int'(in_step) : 0;
        tmo  = 1'b0;
`ifdef DIFFTEST_STEP_BATCH_TIMEOUT_EN
        tmo  = (m_wait == TIMEOUT - 1);
`endif
        fire = !hold && (m_acc > 0) && ((m_acc >= 64) || tmo || m_drain);
        out  = fire ? ((m_acc > 255) ? 255 : m_acc) : 0;
        nxt  = m_acc - out + take;
        if (reset) begin
            m_acc = 0; m_step = 0; m_wait = 0; m_drain = 1'b0;
        end else begin
            m_step = out;
            if (fire || nxt == 0)
                m_wait = 0;
            else if ((m_acc > 0) && !m_drain && !hold && (m_wait < TIMEOUT - 1))
                m_wait = m_wait + 1;
            m_drain = (flush || m_drain) && (nxt != 0);
            m_acc   = nxt;
        end
        #1;
        check("model_step",     difftest_step, m_step);
        check("model_pending",  pending,       m_acc);
        check("model_busy",     busy,          m_acc != 0);
        check("model_in_ready", in_ready,      m_acc <= 496);
    end

    initial begin
        cyc(2);
        check("rst_step", difftest_step, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        reset = 1'b0;

        // Threshold: 16 x 4 from cycle 0
        in_valid = 1'b1; in_step = 4'd4;
        cyc(16);
        in_valid = 1'b0; in_step = '0;
        check("thr_pending_c16", pending, 64);
        check("thr_step_c16", difftest_step, 0);
        cyc(1);
        check("thr_step_c17", difftest_step, 64);
        cyc(1);
        check("thr_step_c18", difftest_step, 0);
        check("thr_pending_c18", pending, 0);
        check("thr_busy_c18", busy, 0);

        // Timeout: single 3 then idle
        do_reset;
        in_valid = 1'b1; in_step = 4'd3;
        cyc(1);
        in_valid = 1'b0; in_step = '0;
`ifdef DIFFTEST_STEP_BATCH_TIMEOUT_EN
        cyc(TIMEOUT - 1);
        check("tmo_step_early", difftest_step, 0);
        check("tmo_pending_early", pending, 3);
        cyc(1);
        check("tmo_step", difftest_step, 3);
        check("tmo_busy", busy, 0);
        cyc(1);
        check("tmo_step_after", difftest_step, 0);

        // Hold for 40 cycles in the middle delays the timeout by 40
        do_reset;
        in_valid = 1'b1; in_step = 4'd3;
        cyc(1);
        in_valid = 1'b0; in_step = '0;
        cyc(99);
        hold = 1'b1;
        cyc(40);
        hold = 1'b0;
        cyc(156);
        check("tmo_hold_step_early", difftest_step, 0);
        cyc(1);
        check("tmo_hold_step", difftest_step, 3);
`else
        cyc(300);
        check("notmo_step", difftest_step, 0);
        check("notmo_pending", pending, 3);
        check("notmo_busy", busy, 1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("notmo_flush_step0", difftest_step, 0);
        check("notmo_flush_busy", busy, 1);
        cyc(1);
        check("notmo_flush_step", difftest_step, 3);
        check("notmo_flush_pending", pending, 0);
        check("notmo_flush_idle", busy, 0);
`endif

        // Drain of an oversized batch
        do_reset;
        hold = 1'b1; in_valid = 1'b1; in_step = 4'd15;
        cyc(20);
        in_valid = 1'b0; in_step = '0;
        check("drain_pending", pending, 300);
        check("drain_step_held", difftest_step, 0);
        hold = 1'b0; flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("drain_step1", difftest_step, 255);
        check("drain_pending1", pending, 45);
        check("drain_busy1", busy, 1);
        cyc(1);
        check("drain_step2", difftest_step, 45);
        check("drain_busy2", busy, 0);
        cyc(1);
        check("drain_step3", difftest_step, 0);

        // Hold with acc = 100
        do_reset;
        hold = 1'b1; in_valid = 1'b1; in_step = 4'd10;
        cyc(10);
        in_valid = 1'b0; in_step = '0;
        cyc(50);
        check("hold_step", difftest_step, 0);
        check("hold_pending", pending, 100);
        hold = 1'b0;
        cyc(1);
        check("hold_release_step", difftest_step, 100);
        check("hold_release_pending", pending, 0);

        // Backpressure: 15 per cycle under hold
        do_reset;
        hold = 1'b1; in_valid = 1'b1; in_step = 4'd15;
        for (int k = 0; k <= 33; k++) begin
            check("bp_ready", in_ready, 1);
            check("bp_pending", pending, 15 * k);
            cyc(1);
        end
        check("bp_full_ready", in_ready, 0);
        check("bp_full_pending", pending, 510);
        cyc(3);
        check("bp_stay_ready", in_ready, 0);
        check("bp_stay_pending", pending, 510);

        // Reset one cycle into DRAIN with acc = 200
        do_reset;
        hold = 1'b1; in_valid = 1'b1; in_step = 4'd10;
        cyc(20);
        in_valid = 1'b0; in_step = '0;
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("rd_busy", busy, 1);
        check("rd_pending", pending, 200);
        reset = 1'b1;
        cyc(1);
        check("rd_step", difftest_step, 0);
        check("rd_pending0", pending, 0);
        check("rd_busy0", busy, 0);
        check("rd_ready", in_ready, 1);
        reset = 1'b0; hold = 1'b0;
        cyc(5);
        check("rd_after_step", difftest_step, 0);
        check("rd_after_busy", busy, 0);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/difftest_step_batcher.md
# difftest_step_batcher

- Sits directly upstream of the DiffTest endpoint.
- Collects per-cycle commit counts from the DUT commit path and emits them as batched `difftest_step` pulses.
- Batching reduces the number of per-step DPI calls on the simulation host.
- A batch is released on a count threshold, on an optional idle timeout, or on an explicit flush; a hold input freezes emission while the endpoint is reporting a result.

## Interface
- `STEP_W`, 8: width of `difftest_step`; must match the endpoint step width.
- `IN_W`, 4: width of the per-cycle commit count.
- `THRESHOLD`, 64: accumulated count at which a batch is emitted; must be ≤ 2^STEP_W−1.
- `TIMEOUT`, 256: idle cycles before a partial batch is forced out; must be ≥ 2.
- `clock` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: commit count valid this cycle.
- `in_step` input IN_W: number of instructions committed this cycle; 0 is legal.
- `in_ready` output 1: batcher can accept `in_step`.
- `flush` input 1: one-cycle request to drain everything pending.
- `hold` input 1: suppress emission; accumulation continues.
- `difftest_step` output STEP_W: registered step count to the endpoint; 0 means no step.
- `pending` output STEP_W+1: current accumulator value.
- `busy` output 1: state ≠ IDLE.

## Operation
- Width rules:
  - Accumulator `acc` is ACC_W = STEP_W+1 bits; ACC_MAX = 2^ACC_W−1.
  - STEP_MAX = 2^STEP_W−1; IN_MAX = 2^IN_W−1.
- `in_ready` = (acc ≤ ACC_MAX−IN_MAX), computed combinationally from registered `acc`.
- Accept happens when `in_valid && in_ready`.
- Emit condition, evaluated only when `!hold`; any one of:
  - acc ≥ THRESHOLD;
  - timer expired;
  - state == DRAIN and acc > 0.
- On emit:
  - `difftest_step` <= min(acc, STEP_MAX).
  - `acc` <= acc − emitted + accepted.
- Otherwise `difftest_step` <= 0 and `acc` <= acc + accepted.
- FSM states: IDLE, COLLECT, DRAIN.
  - IDLE→COLLECT on an accept with nonzero `in_step`.
  - Any→DRAIN on `flush`. `flush` is sampled during `hold` and remembered.
  - COLLECT→IDLE when next acc == 0.
  - DRAIN→IDLE when next acc == 0. Inputs accepted during DRAIN are drained too.
- Timer:
  - Counts cycles in COLLECT with no emit and `!hold`.
  - Cleared on emit, on entering IDLE, and on reset.
  - Expires when the count reaches TIMEOUT−1.
  - Frozen (not cleared) during `hold`.
- Simultaneous cases:
  - `flush` together with threshold: one emission, then DRAIN continues.
  - Accept together with emit: both applied in the same cycle.
- Reset mid-operation discards `acc`, timer and DRAIN; nothing further is emitted.

## Timing
- Reset values: `difftest_step` 0, `pending` 0, `busy` 0, `in_ready` 1, state IDLE, timer 0.
- Latency: an accept in cycle N is visible in `pending` at N+1. If it meets the emit condition, it is visible on `difftest_step` at N+2.
- `difftest_step` is nonzero for exactly one cycle per emission. Back-to-back emissions on consecutive cycles are allowed, e.g. during DRAIN.
- `hold` takes effect in the same cycle it is sampled: no emission is registered from a cycle where `hold` = 1.

## Configuration
- Macro: `DIFFTEST_STEP_BATCH_TIMEOUT_EN`.
- Defined: the idle timer is built and the timeout emit path is active.
- Undefined:
  - No timer logic.
  - Partial batches leave only on threshold or `flush`.
  - `TIMEOUT` is ignored.

## Structure
- Shared package `difftest_batch_pkg` holds:
  - the state enum `batch_state_e` (IDLE, COLLECT, DRAIN);
  - the ACC_W/STEP_MAX derivation helpers.
- One sub-module, `batch_idle_timer`:
  - clear, count-enable and freeze inputs; expired output;
  - instantiated only under `DIFFTEST_STEP_BATCH_TIMEOUT_EN`.

## Test plan
All scenarios use default parameters.
- **Threshold:** `in_step`=4 valid for 16 cycles from cycle 0 → `difftest_step`=64 for one cycle at cycle 17; `pending` returns to 0 at cycle 18.
- **Timeout:** single `in_step`=3, then idle.
  - Macro on → `difftest_step`=3 exactly TIMEOUT cycles later, then state IDLE.
  - Macro off → no emission until `flush`.
- **Drain of an oversized batch:** build acc=300 under `hold`, then drop `hold` and pulse `flush` → `difftest_step`=255, then 45 on the next cycle, then 0; `busy` falls after the second emission.
- **Hold:**
  - acc=100 with `hold`=1 for 50 cycles → `difftest_step` stays 0 and the timer does not advance.
  - Release `hold` → `difftest_step`=100 on the next cycle.
- **Backpressure:** `in_step`=15 every cycle under `hold` → `in_ready` is 1 through acc=495; after acc=510 `in_ready`=0 and `pending` holds 510.
- **Reset mid-drain:** assert `reset` one cycle into DRAIN with acc=200 → the next cycle shows `difftest_step`=0, `pending`=0, `busy`=0, `in_ready`=1.
